// File: rtl/cplx_alu_pipe.sv
// Streaming complex ALU: input reg -> shared-multiplier product stage -> shared-adder combine
// stage -> output FIFO. Define SAT_EN to saturate results instead of wrapping to W bits.
module cplx_alu_pipe #(
  parameter int unsigned W         = 4,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_op,
  input  logic [W-1:0]                 in_a_re,
  input  logic [W-1:0]                 in_a_im,
  input  logic [W-1:0]                 in_b_re,
  input  logic [W-1:0]                 in_b_im,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 real_part,
  output logic [W-1:0]                 imaginary_part,
  output logic [$clog2(OUT_DEPTH):0]   out_count
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned SW = 2 * W + 1;
  localparam int unsigned CW = $clog2(OUT_DEPTH) + 1;
  localparam int unsigned AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  typedef enum logic [1:0] {OpAdd, OpSub, OpMul, OpCmul} op_e;
  typedef enum logic [2:0] {StIdle, StP0, StP1, StP2, StP3} s2_state_e;
  typedef enum logic {StC0, StC1} s3_state_e;

  // Narrow a full-width combine result to W bits.
  function automatic logic [W-1:0] narrow(input logic [SW-1:0] v);
`ifdef SAT_EN
    logic [SW-W:0] hi;
    hi = v[SW-1:W-1];
    if (hi == '0 || hi == '1) begin
      return v[W-1:0];
    end else if (v[SW-1]) begin
      return {1'b1, {(W-1){1'b0}}};
    end else begin
      return {1'b0, {(W-1){1'b1}}};
    end
`else
    return v[W-1:0];
`endif
  endfunction

  function automatic logic [PW-1:0] sext(input logic [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(OUT_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // ---------------------------------------------------------------- state
  logic            s1_valid_q, s1_valid_d;
  op_e             s1_op_q, s1_op_d;
  logic [W-1:0]    s1_a_re_q, s1_a_re_d, s1_a_im_q, s1_a_im_d;
  logic [W-1:0]    s1_b_re_q, s1_b_re_d, s1_b_im_q, s1_b_im_d;

  s2_state_e       s2_state_q, s2_state_d;
  logic [PW-1:0]   p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;

  logic            s3_valid_q, s3_valid_d;
  s3_state_e       s3_state_q, s3_state_d;
  op_e             s3_op_q, s3_op_d;
  logic [PW-1:0]   x0_q, x0_d, x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
  logic [W-1:0]    s3_re_q, s3_re_d;

  logic [W-1:0]    mem_re_q [OUT_DEPTH];
  logic [W-1:0]    mem_re_d [OUT_DEPTH];
  logic [W-1:0]    mem_im_q [OUT_DEPTH];
  logic [W-1:0]    mem_im_d [OUT_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;

  // ---------------------------------------------------------------- handshake
  logic            accept, s2_done, s2_go, s3_take, push, pop, full;
  logic [W-1:0]    push_re, push_im;

  assign full      = (count_q == CW'(OUT_DEPTH));
  assign pop       = (count_q != '0) && out_ready;
  assign push      = s3_valid_q && (s3_state_q == StC1) && (!full || pop);
  assign s3_take   = !s3_valid_q || push;
  assign s2_done   = s1_valid_q && (!s1_op_q[1] || (s2_state_q == StP3));
  assign s2_go     = s2_done && s3_take;
  assign in_ready  = !reset && (!s1_valid_q || s2_go);
  assign accept    = in_valid && in_ready;

  // ---------------------------------------------------------------- S1 input register
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_re_d  = s1_a_re_q;
    s1_a_im_d  = s1_a_im_q;
    s1_b_re_d  = s1_b_re_q;
    s1_b_im_d  = s1_b_im_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = op_e'(in_op);
      s1_a_re_d  = in_a_re;
      s1_a_im_d  = in_a_im;
      s1_b_re_d  = in_b_re;
      s1_b_im_d  = in_b_im;
    end else if (s2_go) begin
      s1_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------- S2 products
  logic [W-1:0]  mul_x, mul_y;
  logic [PW-1:0] prod;

  always_comb begin
    mul_x = s1_a_re_q;
    mul_y = s1_b_re_q;
    unique case (s2_state_q)
      StP1: begin mul_x = s1_a_im_q; mul_y = s1_b_im_q; end
      StP2: begin mul_x = s1_a_re_q; mul_y = s1_b_im_q; end
      StP3: begin mul_x = s1_a_im_q; mul_y = s1_b_re_q; end
      default: ;
    endcase
  end

  assign prod = $signed(sext(mul_x)) * $signed(sext(mul_y));

  always_comb begin
    s2_state_d = s2_state_q;
    p0_d       = p0_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    unique case (s2_state_q)
      StP0: begin p0_d = prod; s2_state_d = StP1; end
      StP1: begin p1_d = prod; s2_state_d = StP2; end
      StP2: begin p2_d = prod; s2_state_d = StP3; end
      default: ;
    endcase
    // A new op always restarts the sequence; P3 waits here until S3 can take it.
    if (accept) begin
      s2_state_d = in_op[1] ? StP0 : StIdle;
    end else if (s2_go) begin
      s2_state_d = StIdle;
    end
  end

  // ---------------------------------------------------------------- S3 combine
  logic [PW-1:0] lhs, rhs;
  logic          sub;
  logic [SW-1:0] sum;

  always_comb begin
    if (s3_state_q == StC0) begin
      lhs = x0_q;
      rhs = x1_q;
      sub = (s3_op_q == OpSub) || (s3_op_q == OpMul);
    end else begin
      lhs = (s3_op_q == OpCmul) ? x3_q : x2_q;
      rhs = (s3_op_q == OpCmul) ? x2_q : x3_q;
      sub = (s3_op_q == OpSub) || (s3_op_q == OpCmul);
    end
    sum = {lhs[PW-1], lhs} + ({rhs[PW-1], rhs} ^ {SW{sub}}) + SW'(sub);
  end

  assign push_re = s3_re_q;
  assign push_im = narrow(sum);

  always_comb begin
    s3_valid_d = s3_valid_q;
    s3_state_d = s3_state_q;
    s3_op_d    = s3_op_q;
    s3_re_d    = s3_re_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    x2_d       = x2_q;
    x3_d       = x3_q;
    if (s3_valid_q && (s3_state_q == StC0)) begin
      s3_re_d    = narrow(sum);
      s3_state_d = StC1;
    end
    if (push) begin
      s3_valid_d = 1'b0;
    end
    if (s2_go) begin
      s3_valid_d = 1'b1;
      s3_state_d = StC0;
      s3_op_d    = s1_op_q;
      if (s1_op_q[1]) begin
        x0_d = p0_q;
        x1_d = p1_q;
        x2_d = p2_q;
        x3_d = prod;
      end else begin
        x0_d = sext(s1_a_re_q);
        x1_d = sext(s1_b_re_q);
        x2_d = sext(s1_a_im_q);
        x3_d = sext(s1_b_im_q);
      end
    end
  end

  // ---------------------------------------------------------------- output FIFO
  always_comb begin
    mem_re_d = mem_re_q;
    mem_im_d = mem_im_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    if (push) begin
      mem_re_d[wptr_q] = push_re;
      mem_im_d[wptr_q] = push_im;
      wptr_d           = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  assign out_valid      = (count_q != '0);
  assign out_count      = count_q;
  assign real_part      = mem_re_q[rptr_q];
  assign imaginary_part = mem_im_q[rptr_q];

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OpAdd;
      s1_a_re_q  <= '0;
      s1_a_im_q  <= '0;
      s1_b_re_q  <= '0;
      s1_b_im_q  <= '0;
      s2_state_q <= StIdle;
      p0_q       <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      s3_valid_q <= 1'b0;
      s3_state_q <= StC0;
      s3_op_q    <= OpAdd;
      s3_re_q    <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      x3_q       <= '0;
      for (int i = 0; i < int'(OUT_DEPTH); i++) begin
        mem_re_q[i] <= '0;
        mem_im_q[i] <= '0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_re_q  <= s1_a_re_d;
      s1_a_im_q  <= s1_a_im_d;
      s1_b_re_q  <= s1_b_re_d;
      s1_b_im_q  <= s1_b_im_d;
      s2_state_q <= s2_state_d;
      p0_q       <= p0_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      s3_valid_q <= s3_valid_d;
      s3_state_q <= s3_state_d;
      s3_op_q    <= s3_op_d;
      s3_re_q    <= s3_re_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      x3_q       <= x3_d;
      mem_re_q   <= mem_re_d;
      mem_im_q   <= mem_im_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_cplx_alu_pipe.sv
// Self-checking bench for cplx_alu_pipe: directed test-plan cases plus a randomized stream
// scored against a complex-arithmetic reference queue.
module tb_cplx_alu_pipe;

  localparam int W  = 4;
  localparam int D  = 2;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_a_re, in_a_im, in_b_re, in_b_im;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  real_part, imaginary_part;
  logic [CW-1:0] out_count;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];
  logic last_acc;

  cplx_alu_pipe #(.W(W), .OUT_DEPTH(D)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_a_re        (in_a_re),
    .in_a_im        (in_a_im),
    .in_b_re        (in_b_re),
    .in_b_im        (in_b_im),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .real_part      (real_part),
    .imaginary_part (imaginary_part),
    .out_count      (out_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] fit(input int v);
    int r;
    r = v;
`ifdef SAT_EN
    if (r > (1 << (W - 1)) - 1) r = (1 << (W - 1)) - 1;
    if (r < -(1 << (W - 1)))    r = -(1 << (W - 1));
`endif
    return W'(r);
  endfunction

  function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] ar,
                                           input logic [W-1:0] ai, input logic [W-1:0] br,
                                           input logic [W-1:0] bi);
    int a_r, a_i, b_r, b_i, re, im;
    a_r = int'($signed(ar));
    a_i = int'($signed(ai));
    b_r = int'($signed(br));
    b_i = int'($signed(bi));
    case (op)
      2'd0:    begin re = a_r + b_r; im = a_i + b_i; end
      2'd1:    begin re = a_r - b_r; im = a_i - b_i; end
      2'd2:    begin re = a_r * b_r - a_i * b_i; im = a_r * b_i + a_i * b_r; end
      default: begin re = a_r * b_r + a_i * b_i; im = a_i * b_r - a_r * b_i; end
    endcase
    return {fit(re), fit(im)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: sample handshakes just before the edge, score pops, land on the next negedge.
  task automatic cyc();
    logic [2*W-1:0] e;
    #1;
    last_acc = in_valid && in_ready;
    if (!reset) begin
      if (last_acc) exp_q.push_back(model(in_op, in_a_re, in_a_im, in_b_re, in_b_im));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", {real_part, imaginary_part}, 32'hdead);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", {24'h0, real_part, imaginary_part}, {24'h0, e});
        end
      end
    end
    @(posedge clk);
    if (reset) exp_q.delete();
    @(negedge clk);
  endtask

  task automatic set_op(input logic [1:0] op, input logic [W-1:0] ar, input logic [W-1:0] ai,
                        input logic [W-1:0] br, input logic [W-1:0] bi);
    in_op   = op;
    in_a_re = ar;
    in_a_im = ai;
    in_b_re = br;
    in_b_im = bi;
  endtask

  task automatic run_one(input string tag, input logic [1:0] op, input logic [W-1:0] ar,
                         input logic [W-1:0] ai, input logic [W-1:0] br, input logic [W-1:0] bi,
                         input logic [W-1:0] xre, input logic [W-1:0] xim, input int xlat);
    int lat;
    set_op(op, ar, ai, br, bi);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc();
    chk({tag, "_accept"}, 32'(last_acc), 32'd1);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      cyc();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(xlat));
    chk({tag, "_value"}, {24'h0, real_part, imaginary_part}, {24'h0, xre, xim});
    cyc();
  endtask

  initial begin
    int acc;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_op(2'd0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_real", 32'(real_part), 32'd0);
    chk("rst_imag", 32'(imaginary_part), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc();

    run_one("add", 2'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'h4, 4'h6, 3);
    run_one("sub", 2'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'hE, 4'hE, 3);
`ifdef SAT_EN
    run_one("mul", 2'd2, 4'd1, 4'd2, 4'd3, 4'd4, 4'hB, 4'h7, 6);
    run_one("cmul", 2'd3, 4'd1, 4'd2, 4'd3, 4'd4, 4'h7, 4'h2, 6);
`else
    run_one("mul", 2'd2, 4'd1, 4'd2, 4'd3, 4'd4, 4'hB, 4'hA, 6);
    run_one("cmul", 2'd3, 4'd1, 4'd2, 4'd3, 4'd4, 4'hB, 4'h2, 6);
`endif

    // Back-pressure: five adds against a stalled consumer.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = (acc < 5);
      if (!last_acc || i == 0) set_op(2'd0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      cyc();
      if (last_acc) acc++;
    end
    #1;
    chk("stall_count", 32'(out_count), 32'(D));
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_not_all_accepted", 32'(acc < 5), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_valid = (acc < 5);
      if (last_acc) set_op(2'd0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      cyc();
      if (last_acc) acc++;
    end
    chk("stall_all_accepted", 32'(acc), 32'd5);
    chk("stall_drained", 32'(exp_q.size()), 32'd0);

    // Reset while a multiply is in its third product cycle.
    set_op(2'd2, 4'd7, 4'd7, 4'd7, 4'd7);
    in_valid = 1'b1;
    cyc();
    chk("abort_accept", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_count", 32'(out_count), 32'd0);
    repeat (12) cyc();
    chk("abort_nothing_out", 32'(out_count), 32'd0);
    run_one("after_abort", 2'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'h4, 4'h6, 3);

    // Randomized mixed stream with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      set_op(2'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) cyc();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_fifo_empty", 32'(out_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cplx_alu_pipe.md
Name: cplx_alu_pipe

Overview:
Parametrised successor of the 4-bit complex ALU pipeline. It takes a stream of complex operations over a valid/ready interface instead of fetching from an internal memory. The datapath is W-bit signed two's complement with one shared multiplier and one shared adder, and it supports add, sub, multiply and conjugate-multiply. Results leave through an OUT_DEPTH output FIFO with valid/ready back-pressure. It sits between the instruction source (memory/fetch or a bench) and the result consumer.

Parameters:
W, 4, operand and result width (signed two's complement), 2..16
OUT_DEPTH, 2, output FIFO entries, power of 2, >=1

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  operation offered
in_ready  output  1  operation accepted on edge where in_valid&&in_ready
in_op  input  2  00 add, 01 sub, 10 mul, 11 conj-mul (a*conj(b))
in_a_re, in_a_im, in_b_re, in_b_im  input  W each  operands a=(a_re+j a_im), b=(b_re+j b_im)
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer takes head on edge where out_valid&&out_ready
real_part  output  W  FIFO head real
imaginary_part  output  W  FIFO head imaginary
out_count  output  clog2(OUT_DEPTH)+1  FIFO occupancy

Behaviour:
- Interface decided: one clock; reset synchronous, active-high; ports named clk and reset.
- Reset: all stage-valid flags 0, counters 0, FIFO empty; out_valid=0, out_count=0, real_part=0, imaginary_part=0, in_ready=0 while reset high. Reset mid-operation discards all in-flight ops. No partial result ever reaches the FIFO.
- Stage S1 (input reg): in_ready = !reset && (S1 empty || S1 moving to S2 this edge).
- Stage S2 (products, FSM IDLE/P0/P1/P2/P3):
  - add/sub: pass operands in 1 cycle.
  - mul/conj-mul: one multiplier, one 2W-bit signed product per cycle, in order P0=a_re*b_re, P1=a_im*b_im, P2=a_re*b_im, P3=a_im*b_re; 4 cycles.
  - S2 holds its result while S3 is busy.
- Stage S3 (combine, FSM C0/C1): one adder of width 2W+1, 2 cycles, real first, then imaginary.
  - add: re=a_re+b_re, im=a_im+b_im.
  - sub: a-b.
  - mul: re=P0-P1, im=P2+P3.
  - conj-mul: re=P0+P1, im=P3-P2.
- Result narrowing to W bits: keep the low W bits (wrap); see SAT_EN for the alternative.
- S3 writes {re,im} to the FIFO at the end of C1 only if FIFO not full, or if a pop happens on the same edge. Otherwise S3 stalls in C1, and the stall back-propagates to S2, S1 and in_ready.
- Latency, no stalls (accept edge = k): add/sub result written to FIFO on edge k+3; mul/conj-mul on edge k+6. out_valid is high from the cycle after the write.
- Throughput: one add/sub per 2 cycles; one mul per 4 cycles.
- Ordering: strictly in order; mixed ops never overtake.
- FIFO:
  - Simultaneous push and pop when full: both happen, count unchanged.
  - Push and pop when empty: push lands, no bypass; result is visible next cycle.
  - Pop when empty: ignored.
  - Pointers wrap modulo OUT_DEPTH.
- Outputs are driven from the FIFO head, registered, and held stable while out_valid && !out_ready.

Optional Feature:
SAT_EN.
- Defined: real and imaginary results saturate to [-2^(W-1), 2^(W-1)-1] instead of wrapping. This applies to all four ops and is computed from the full-width 2W+1 value. Latency is unchanged.
- Undefined: low-W-bit wrap as above.

Test Plan:
- W=4, add (1+2j)+(3+4j), out_ready=1 -> real_part=4'h4, imaginary_part=4'h6, out_valid 3 cycles after accept.
- sub (1+2j)-(3+4j) -> 4'hE, 4'hE.
- mul (1+2j)*(3+4j) -> -5+10j: without SAT_EN 4'hB, 4'hA; with SAT_EN 4'hB, 4'h7; out_valid 6 cycles after accept.
- conj-mul (1+2j)*conj(3+4j) -> 11+2j: without SAT_EN 4'hB, 4'h2; with SAT_EN 4'h7, 4'h2.
- out_ready=0, stream 5 adds with OUT_DEPTH=2 -> out_count reaches 2, in_ready drops, no loss; out_ready=1 -> the 5 results drain in input order.
- Reset high for 1 cycle during mul stage P2 -> out_valid=0, out_count=0; next op after reset returns its correct result, and nothing from the aborted op appears.
